lcd_byte_arbiter: RTL and testbench

- Runtime transport for the 4-bit character LCD once power-on initialisation is done.
- Arbitrates between two byte-level requesters: port 0 (command/control path) and port 1 (display/character writer for rotary-encoder readout).
- Splits the granted byte into upper and lower nibbles and drives LCD_E, LCD_RS, LCD_RW and data with the required setup, pulse-width and post-command delays.
- Returns a one-cycle ack to the owner when the LCD is ready for the next byte.

---
 rtl/lcd_byte_arbiter.sv | 155 +++++++++++++++
 tb/tb_lcd_byte_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_byte_arbiter.sv
// Byte arbiter and 4-bit nibble transport for the character LCD after power-on init.
// Optional macro LCD_ARB_RR_EN selects round-robin arbitration instead of fixed priority (port 0 first).
module lcd_byte_arbiter #(
  parameter int T_SETUP   = 2,
  parameter int T_E_HIGH  = 12,
  parameter int T_NIB_GAP = 50,
  parameter int T_CMD_GAP = 2000,
  parameter int T_CLR     = 82000,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] byte0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] byte1,
  output logic       ack1,
  output logic       busy,
  output logic       owner,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  typedef enum logic [2:0] {IDLE, SET_H, E_H, GAP, SET_L, E_L, WAIT, ACK} state_t;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EHIGH = CNT_W'(T_E_HIGH - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_NIB_GAP - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD_GAP - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_rs;
  logic [7:0]       lat_byte;
  logic             any_req;
  logic             sel;
  logic             sel_rs;
  logic [7:0]       sel_byte;
  logic             cnt_done;
  logic             is_clr;

  assign any_req  = req0 | req1;
  assign cnt_done = (cnt == '0);
  assign sel_rs   = sel ? rs1 : rs0;
  assign sel_byte = sel ? byte1 : byte0;
  // Clear display and return home need the long busy time.
  assign is_clr   = !lat_rs && ((lat_byte == 8'h01) || (lat_byte == 8'h02));
  assign lcd_rw   = 1'b0;

`ifdef LCD_ARB_RR_EN
  logic rr_ptr;

  assign sel = (req0 && req1) ? rr_ptr : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (state == IDLE && any_req) begin
      rr_ptr <= ~sel;
    end
  end
`else
  assign sel = ~req0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_rs   <= 1'b0;
      lat_byte <= 8'h00;
      owner    <= 1'b0;
      busy     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_d    <= 4'h0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      // Every timed state loads param-1 on entry and exits at zero, so this never wraps.
      if (!cnt_done) cnt <= cnt - CNT_W'(1);
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= SET_H;
            cnt      <= LD_SETUP;
            lat_rs   <= sel_rs;
            lat_byte <= sel_byte;
            owner    <= sel;
            busy     <= 1'b1;
            lcd_rs   <= sel_rs;
            lcd_d    <= sel_byte[7:4];
            lcd_e    <= 1'b0;
          end
        end
        SET_H: begin
          if (cnt_done) begin
            state <= E_H;
            cnt   <= LD_EHIGH;
            lcd_e <= 1'b1;
          end
        end
        E_H: begin
          if (cnt_done) begin
            state <= GAP;
            cnt   <= LD_GAP;
            lcd_e <= 1'b0;
          end
        end
        GAP: begin
          if (cnt_done) begin
            state <= SET_L;
            cnt   <= LD_SETUP;
            lcd_d <= lat_byte[3:0];
          end
        end
        SET_L: begin
          if (cnt_done) begin
            state <= E_L;
            cnt   <= LD_EHIGH;
            lcd_e <= 1'b1;
          end
        end
        E_L: begin
          if (cnt_done) begin
            state <= WAIT;
            cnt   <= is_clr ? LD_CLR : LD_CMD;
            lcd_e <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_done) begin
            state <= ACK;
            ack0  <= ~owner;
            ack1  <= owner;
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_byte_arbiter.sv
// Self-checking bench for lcd_byte_arbiter with short timing parameters and a transaction-level model.
// Honours LCD_ARB_RR_EN so the arbitration model matches the build under test.
module tb_lcd_byte_arbiter;

  localparam int TS = 1;
  localparam int TE = 2;
  localparam int TG = 3;
  localparam int TC = 5;
  localparam int TL = 20;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, rs0, req1, rs1;
  logic [7:0] byte0, byte1;
  logic       ack0, ack1, busy, owner, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  int checks = 0;
  int errors = 0;

  lcd_byte_arbiter #(
    .T_SETUP(TS), .T_E_HIGH(TE), .T_NIB_GAP(TG), .T_CMD_GAP(TC), .T_CLR(TL), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rs0(rs0), .byte0(byte0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .byte1(byte1), .ack1(ack1),
    .busy(busy), .owner(owner),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
  );

  always #5 clk = ~clk;

  // Cycles from the IDLE sampling edge until ack is seen, from the timing rules.
  function automatic int exp_lat(input logic rs, input logic [7:0] b);
    return 1 + 2 * TS + 2 * TE + TG + ((!rs && (b == 8'h01 || b == 8'h02)) ? TL : TC);
  endfunction

  // Drives one request, watches the LCD pins and returns what was observed.
  task automatic run_xfer(input logic port, input logic rs, input logic [7:0] b, input logic mid,
                          output int lat, output logic [7:0] got, output logic [1:0] got_rs,
                          output int pre, output int ew0, output int ew1, output int low_mid,
                          output logic stray, output logic own);
    int   pulses;
    int   w;
    logic prev_e;
    lat = -1; got = 8'h00; got_rs = 2'b00; pre = 0; ew0 = 0; ew1 = 0; low_mid = 0;
    stray = 1'b0; own = 1'bx; pulses = 0; prev_e = 1'b0;
    @(negedge clk);
    w = 0;
    while (busy !== 1'b0 && w < TIMEOUT) begin
      @(negedge clk);
      w++;
    end
    if (port == 1'b0) begin
      req0 = 1'b1; rs0 = rs; byte0 = b;
    end else begin
      req1 = 1'b1; rs1 = rs; byte1 = b;
    end
    for (int n = 1; n <= TIMEOUT; n++) begin
      @(negedge clk);
      if (lcd_e && !prev_e) begin
        if (pulses == 0) begin
          got[7:4] = lcd_d; got_rs[1] = lcd_rs; own = owner;
          if (mid) begin
            if (port) begin byte1 = 8'h7F; rs1 = ~rs; end
            else begin byte0 = 8'h7F; rs0 = ~rs; end
          end
        end else if (pulses == 1) begin
          got[3:0] = lcd_d; got_rs[0] = lcd_rs;
        end
        pulses++;
      end
      if (mid && !lcd_e && prev_e && pulses == 1) begin
        if (port) req1 = 1'b0; else req0 = 1'b0;
      end
      if (lcd_e) begin
        if (pulses == 1) ew0++;
        else if (pulses == 2) ew1++;
      end else begin
        if (pulses == 0) pre++;
        else if (pulses == 1) low_mid++;
      end
      if (port ? ack0 : ack1) stray = 1'b1;
      prev_e = lcd_e;
      if (port ? ack1 : ack0) begin
        lat = n;
        break;
      end
    end
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int lat, pre, ew0, ew1, lm;
    logic [7:0] got;
    logic [1:0] grs;
    logic stray, own;
    rst = 1'b1; req0 = 1'b0; rs0 = 1'b0; byte0 = 8'h00; req1 = 1'b0; rs1 = 1'b0; byte1 = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_e, lcd_rs, lcd_rw, busy, owner, ack0, ack1, lcd_d} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0", {lcd_e, lcd_rs, lcd_rw, busy, owner, ack0, ack1, lcd_d});
    end
    rst = 1'b0;
    @(negedge clk);
    req0 = 1'b1; rs0 = 1'b1; byte0 = 8'hFF;
    n = 0;
    while (lcd_e !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (lcd_e !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_reach_e_high: lcd_e %b expected 1", lcd_e);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({lcd_e, busy, ack0, ack1, lcd_d} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid_pulse: got %b expected 0", {lcd_e, busy, ack0, ack1, lcd_d});
    end
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_after_release: busy %b expected 0", busy);
    end
    run_xfer(1'b0, 1'b0, 8'h38, 1'b0, lat, got, grs, pre, ew0, ew1, lm, stray, own);
    checks++;
    if (lat !== exp_lat(1'b0, 8'h38) || got !== 8'h38 || grs !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_then_xfer: lat %0d byte %h rs %b expected lat %0d byte 38 rs 00",
               lat, got, grs, exp_lat(1'b0, 8'h38));
    end
  endtask

  task automatic test_single_char();
    int lat, pre, ew0, ew1, lm;
    logic [7:0] got;
    logic [1:0] grs;
    logic stray, own;
    run_xfer(1'b1, 1'b1, 8'h4C, 1'b0, lat, got, grs, pre, ew0, ew1, lm, stray, own);
    checks++;
    if (got !== 8'h4C || grs !== 2'b11) begin
      errors++;
      $display("[TB] FAIL char_nibbles: byte %h rs %b expected 4c rs 11", got, grs);
    end
    checks++;
    if (pre !== TS || ew0 !== TE || ew1 !== TE || lm !== TG + TS) begin
      errors++;
      $display("[TB] FAIL char_widths: setup %0d e_hi %0d/%0d low_between %0d expected %0d %0d/%0d %0d",
               pre, ew0, ew1, lm, TS, TE, TE, TG + TS);
    end
    checks++;
    if (lat !== 15 || stray !== 1'b0 || own !== 1'b1) begin
      errors++;
      $display("[TB] FAIL char_ack: lat %0d stray_ack0 %b owner %b expected 15 0 1", lat, stray, own);
    end
    checks++;
    if (lcd_rw !== 1'b0 || lcd_d !== 4'hC || lcd_rs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL char_hold: rw %b d %h rs %b expected 0 c 1", lcd_rw, lcd_d, lcd_rs);
    end
  endtask

  task automatic test_clear_timing();
    logic [7:0] bytes [4] = '{8'h01, 8'h02, 8'h0C, 8'h01};
    logic       rss   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int         want  [4] = '{30, 30, 15, 15};
    int lat, pre, ew0, ew1, lm;
    logic [7:0] got;
    logic [1:0] grs;
    logic stray, own;
    for (int i = 0; i < 4; i++) begin
      run_xfer(1'b0, rss[i], bytes[i], 1'b0, lat, got, grs, pre, ew0, ew1, lm, stray, own);
      checks++;
      if (lat !== want[i] || got !== bytes[i] || stray !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clear_timing[%0d]: lat %0d byte %h stray %b expected %0d %h 0",
                 i, lat, got, stray, want[i], bytes[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat, pre, ew0, ew1, lm;
    logic [7:0] got, b;
    logic [1:0] grs;
    logic stray, own, p, rs;
    for (int i = 0; i < 12; i++) begin
      p  = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      run_xfer(p, rs, b, 1'b0, lat, got, grs, pre, ew0, ew1, lm, stray, own);
      checks++;
      if (lat !== exp_lat(rs, b) || got !== b || grs !== {rs, rs} || stray !== 1'b0 || own !== p) begin
        errors++;
        $display("[TB] FAIL random[%0d]: port %b lat %0d byte %h rs %b stray %b owner %b expected lat %0d byte %h rs %b",
                 i, p, lat, got, grs, stray, own, exp_lat(rs, b), b, {rs, rs});
      end
    end
  endtask

  task automatic test_contention();
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       exp_w[$];
    logic [8:0] cur;
    logic [7:0] asm_byte;
    logic       ptr, w, prev_e;
    int         r0, r1, k, since, pulses;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(9'($urandom));
      q1.push_back(9'($urandom));
    end
    r0 = 3; r1 = 3; ptr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (r0 > 0 && r1 > 0) begin
`ifdef LCD_ARB_RR_EN
        w = ptr;
`else
        w = 1'b0;
`endif
      end else begin
        w = (r0 > 0) ? 1'b0 : 1'b1;
      end
      ptr = ~w;
      exp_w.push_back(w);
      if (w) r1--; else r0--;
    end
    rst = 1'b1;
    @(negedge clk);
    req0 = 1'b1; {rs0, byte0} = q0[0];
    req1 = 1'b1; {rs1, byte1} = q1[0];
    @(negedge clk);
    rst = 1'b0;
    k = 0; since = 0; pulses = 0; prev_e = 1'b0; asm_byte = 8'h00;
    for (int n = 0; n < 2000 && k < 6; n++) begin
      @(negedge clk);
      since++;
      if (lcd_e && !prev_e) begin
        if (pulses % 2 == 0) asm_byte[7:4] = lcd_d; else asm_byte[3:0] = lcd_d;
        pulses++;
      end
      prev_e = lcd_e;
      if (ack0 || ack1) begin
        w = ack1;
        if (w) cur = (q1.size() > 0) ? q1[0] : 9'h000;
        else   cur = (q0.size() > 0) ? q0[0] : 9'h000;
        checks++;
        if ((ack0 && ack1) || w !== exp_w[k]) begin
          errors++;
          $display("[TB] FAIL contention_order[%0d]: acks %b%b expected port %b", k, ack1, ack0, exp_w[k]);
        end
        checks++;
        if (asm_byte !== cur[7:0] || lcd_rs !== cur[8]) begin
          errors++;
          $display("[TB] FAIL contention_data[%0d]: byte %h rs %b expected %h %b", k, asm_byte, lcd_rs, cur[7:0], cur[8]);
        end
        checks++;
        if (since !== exp_lat(cur[8], cur[7:0]) + ((k == 0) ? 0 : 1)) begin
          errors++;
          $display("[TB] FAIL contention_spacing[%0d]: cycles %0d expected %0d", k, since,
                   exp_lat(cur[8], cur[7:0]) + ((k == 0) ? 0 : 1));
        end
        if (w) begin
          if (q1.size() > 0) void'(q1.pop_front());
          if (q1.size() > 0) {rs1, byte1} = q1[0]; else req1 = 1'b0;
        end else begin
          if (q0.size() > 0) void'(q0.pop_front());
          if (q0.size() > 0) {rs0, byte0} = q0[0]; else req0 = 1'b0;
        end
        since = 0;
        k++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (k !== 6) begin
      errors++;
      $display("[TB] FAIL contention_count: acks %0d expected 6", k);
    end
  endtask

  task automatic test_mid_change();
    int lat, pre, ew0, ew1, lm;
    logic [7:0] got;
    logic [1:0] grs;
    logic stray, own, extra;
    run_xfer(1'b1, 1'b1, 8'h41, 1'b1, lat, got, grs, pre, ew0, ew1, lm, stray, own);
    checks++;
    if (got !== 8'h41 || grs !== 2'b11 || lat !== 15) begin
      errors++;
      $display("[TB] FAIL mid_change_xfer: byte %h rs %b lat %0d expected 41 11 15", got, grs, lat);
    end
    extra = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || lcd_e !== 1'b0 || ack1 !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_change_no_retry: activity %b expected 0", extra);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_char();
    test_clear_timing();
    test_random();
    test_mid_change();
    test_contention();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
